// File: rtl/wb_common_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes, memory-slave FSM states
// and the burst next-address function. ST_WAIT exists only with WB_MEM_SLAVE_WAIT_EN.
package wb_common_pkg;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] CONST   = 3'b001;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] END     = 3'b111;

  localparam logic [1:0] LINEAR  = 2'b00;
  localparam logic [1:0] WRAP4   = 2'b01;
  localparam logic [1:0] WRAP8   = 2'b10;
  localparam logic [1:0] WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1
`ifdef WB_MEM_SLAVE_WAIT_EN
    , ST_WAIT = 2'd2
`endif
  } mem_state_e;

  // Word address of the beat following adr; wrapped bursts only move the low bits.
  function automatic logic [31:0] wb_next_adr(input logic [31:0] adr,
                                              input logic [2:0]  cti,
                                              input logic [1:0]  bte);
    logic [31:0] nxt;
    nxt = adr;
    if (cti == INCR) begin
      case (bte)
        LINEAR:  nxt = adr + 32'd1;
        WRAP4:   nxt = {adr[31:2], adr[1:0] + 2'd1};
        WRAP8:   nxt = {adr[31:3], adr[2:0] + 3'd1};
        default: nxt = {adr[31:4], adr[3:0] + 4'd1};
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wb_mem_slave_ram.sv
// Single-port byte-enable RAM with a registered read port; the read register
// resets to zero so the bus data output starts clean.
module wb_mem_slave_ram #(
  parameter int DW    = 32,
  parameter int WORDS = 256,
  localparam int NB   = DW / 8,
  localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic          we,
  input  logic [NB-1:0] sel,
  input  logic [IW-1:0] adr,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (sel[b]) mem[adr][b*8 +: 8] <= wdat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdat <= '0;
    else if (re) rdat <= mem[adr];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B3 memory slave: classic and registered-feedback bursts, err on
// out-of-range words. Optional WAIT state before each beat via WB_MEM_SLAVE_WAIT_EN.
module wb_mem_slave
  import wb_common_pkg::*;
#(
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic [1:0]      dbg_state
);

  localparam int ADR_LSB = $clog2(dw / 8);
  localparam int WA      = aw - ADR_LSB;
  localparam int IW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("wb_mem_slave: WAIT_STATES must be 0..15");
  end
  if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("wb_mem_slave: MEM_WORDS must be a power of two");
  end

  mem_state_e    state_q, state_d;
  logic [WA-1:0] adr_q, adr_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
`ifdef WB_MEM_SLAVE_WAIT_EN
  logic [3:0]    wcnt_q, wcnt_d;
`endif

  logic          req;
  logic [WA-1:0] req_word;
  logic [31:0]   next_adr;
  logic [31:0]   beat_adr;
  logic          beat_ok;
  logic          enter_beat;
  logic          burst_more;
  logic          ram_re, ram_we;
  logic [IW-1:0] ram_adr;
  logic          unused_adr_lsb;

  // Handshake: a beat completes on any edge where cyc, stb and ack (or err) are all
  // high; ack/err are masked by cyc&stb so an abort hides them in the same cycle.
  assign req            = wb_cyc_i & wb_stb_i;
  assign req_word       = wb_adr_i[aw-1:ADR_LSB];
  assign unused_adr_lsb = ^wb_adr_i[ADR_LSB-1:0];
  assign next_adr       = wb_next_adr(32'(adr_q), cti_q, bte_q);
  assign burst_more     = req & ~err_q & ((cti_q == CONST) | (cti_q == INCR)) & (wb_cti_i != END);

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    cti_d      = cti_q;
    bte_d      = bte_q;
    ack_d      = ack_q;
    err_d      = err_q;
`ifdef WB_MEM_SLAVE_WAIT_EN
    wcnt_d     = wcnt_q;
`endif
    beat_adr   = 32'(adr_q);
    enter_beat = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cti_d    = wb_cti_i;
          bte_d    = wb_bte_i;
          adr_d    = req_word;
          beat_adr = 32'(req_word);
`ifdef WB_MEM_SLAVE_WAIT_EN
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            wcnt_d  = 4'(WAIT_STATES - 1);
          end else begin
            enter_beat = 1'b1;
          end
`else
          enter_beat = 1'b1;
`endif
        end
      end
      ST_BEAT: begin
        if (!burst_more) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          beat_adr = next_adr;
          adr_d    = next_adr[WA-1:0];
`ifdef WB_MEM_SLAVE_WAIT_EN
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            ack_d   = 1'b0;
            wcnt_d  = 4'(WAIT_STATES - 1);
          end else begin
            enter_beat = 1'b1;
          end
`else
          enter_beat = 1'b1;
`endif
        end
      end
`ifdef WB_MEM_SLAVE_WAIT_EN
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd0) begin
          enter_beat = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Range is judged on the full 32-bit word address so a linear burst running
    // off the top of the address space still errs instead of aliasing.
    beat_ok = beat_adr < MEM_LIMIT;
    if (enter_beat) begin
      state_d = ST_BEAT;
      adr_d   = beat_adr[WA-1:0];
      ack_d   = beat_ok;
      err_d   = ~beat_ok;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      cti_q   <= CLASSIC;
      bte_q   <= LINEAR;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_MEM_SLAVE_WAIT_EN
      wcnt_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef WB_MEM_SLAVE_WAIT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  // One port: a committing write beat owns the address, so the prefetch is
  // skipped then (read data is meaningless during a write burst anyway).
  assign ram_we  = ack_q & req & wb_we_i;
  assign ram_re  = enter_beat & beat_ok & ~ram_we;
  assign ram_adr = ram_we ? adr_q[IW-1:0] : beat_adr[IW-1:0];

  wb_mem_slave_ram #(
    .DW    (dw),
    .WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .re    (ram_re),
    .we    (ram_we),
    .sel   (wb_sel_i),
    .adr   (ram_adr),
    .wdat  (wb_dat_i),
    .rdat  (wb_dat_o)
  );

  assign wb_ack_o  = ack_q & req;
  assign wb_err_o  = err_q & req;
  assign wb_rty_o  = 1'b0;
  assign dbg_state = state_q;

endmodule
